rca_chunk_serial_adder: RTL
===========================

Name: rca_chunk_serial_adder

Overview:
- Parametrised, multi-cycle successor to the 16-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock. The carry is kept in a register between chunks, so the combinational ripple path is only CHUNK bits long.
- Valid/ready handshake on input and output, carry-in/borrow-in, carry-out and signed-overflow flags.
- Used in datapaths where area matters more than throughput.

Parameters:
- WIDTH, 16, operand/result width in bits; must satisfy WIDTH % CHUNK == 0.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A (unsigned or two's complement)
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = A+B+cin, 1 = A-B-cin
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  raw carry out of the MSB
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, chunk counter=0, carry reg=0, all internal registers 0.
  - Outputs: in_ready=1 (IDLE), out_valid=0, sum=0, cout=0, ovf=0.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready at an edge:
    - latch a; latch b_eff = sub ? ~b : b.
    - carry reg <= cin ^ sub.
    - counter <= 0; go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - add chunk k of a and b_eff with carry reg (ripple, combinational).
    - write the result into sum bits [k*CHUNK +: CHUNK]; carry reg <= chunk carry-out; counter++.
    - On the last chunk (k == NCHUNK-1): capture cout and ovf from that chunk, go to DONE.
  - DONE: out_valid=1, in_ready=0.
    - sum/cout/ovf held stable while out_ready=0.
    - On out_ready: go to IDLE, out_valid drops next cycle.
    - sum/cout/ovf keep their last values until the next operation overwrites them.
- Latency:
  - Accept at edge T -> out_valid=1 after edge T+NCHUNK.
  - Throughput: one operation per NCHUNK+2 cycles at best (no overlap of accept and result).
- Subtract:
  - A + ~B + (cin^sub); cin=1 with sub=1 subtracts one more (borrow-in).
  - cout=1 means no borrow.
- CHUNK==WIDTH: RUN lasts exactly one cycle; latency 1.
- in_valid while in_ready=0: ignored, no state change. Operands are sampled only at the accepting edge; a/b/cin/sub changing later have no effect.
- out_ready high when out_valid=0: no effect.
- Reset during RUN or DONE: operation discarded, no result produced; the block is ready again the cycle after rst_n deasserts.
- No X on any output after reset, including for CHUNK=1.

Decomposition:
- Package rca_pkg: state enum typedef (IDLE, RUN, DONE), 2-bit encoding.
- Sub-module rca_chunk (combinational, parameter CHUNK):
  - inputs a, b, ci; outputs s, co, c_msb (carry into the chunk MSB).
  - Built as a ripple of full-adder bits.
  - Instantiated once; shared across all chunk positions via operand mux and shift.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- a=0x1234 b=0x4321 cin=0 sub=0 -> sum=0x5555 cout=0 ovf=0; out_valid exactly 4 cycles after accept, in_ready=0 throughout.
- a=0xFFFF b=0x0001 cin=0 sub=0 -> sum=0x0000 cout=1 ovf=0; a=0x7FFF b=0x0001 -> sum=0x8000 cout=0 ovf=1; a=0x0000 b=0x0000 cin=1 -> sum=0x0001.
- sub=1: a=0x0005 b=0x0007 cin=0 -> sum=0xFFFE cout=0 ovf=0; a=0x8000 b=0x0001 cin=0 -> sum=0x7FFF cout=1 ovf=1; a=0x0009 b=0x0003 cin=1 -> sum=0x0005 cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> sum/cout/ovf stable, in_ready=0, new operands not taken; after out_ready pulse, next accept computes the new operands correctly.
- Reset mid-RUN: drop rst_n after 2 chunks -> outputs immediately 0, in_ready=1, out_valid never rises for the aborted op; next op a=0x00FF b=0x0001 -> sum=0x0100.
- Parameter sweep: (WIDTH,CHUNK) = (16,1), (16,16), (32,8); 1000 random ops each against a behavioural a±b±cin model -> sum/cout/ovf match; latency equals NCHUNK.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared types for the chunk-serial ripple-carry adder.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package rca_pkg;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a counter that indexes n chunks; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple of full adders.
// Latency: purely combinational, CHUNK full-adder stages deep.
// Backpressure: none; the caller sequences the operands.
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic carry;

  // Ripple the carry LSB to MSB; c_msb keeps the carry entering the top bit.
  always_comb begin
    carry = ci;
    c_msb = ci;
    s     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      c_msb = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/rca_chunk_serial_adder.sv
// Multi-cycle add/subtract of WIDTH-bit operands, CHUNK bits per clock.
// Latency: accept at edge T, out_valid high after edge T+NCHUNK.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module rca_chunk_serial_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_w(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  // Operand registers shift right one chunk per RUN cycle, so the shared
  // adder always sees the current chunk in the low bits.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [CHUNK-1:0] ch_s;
  logic             ch_co;
  logic             ch_cmsb;

  rca_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .ci    (carry),
    .s     (ch_s),
    .co    (ch_co),
    .c_msb (ch_cmsb)
  );

  // Handshake flags decode straight from the state.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Controller and datapath: latch on accept, one chunk per RUN cycle, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            // Subtraction is A + ~B + 1; a borrow-in cancels the +1.
            b_q   <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum[int'(cnt)*CHUNK +: CHUNK] <= ch_s;
          carry <= ch_co;
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout  <= ch_co;
            ovf   <= ch_co ^ ch_cmsb;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
